// File: rtl/serial_stream_tx_if.sv
// ============================================================================
// Module      : serial_stream_tx_if
// Description : Load handshake and serial output bundle for serial_stream_tx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_stream_tx_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 3
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic             load_ready;
    logic             x;
    logic             x_valid;
    logic             done;
    logic             z_exp;

    modport master (
        output load_valid, load_data, load_len,
        input  load_ready, x, x_valid, done, z_exp
    );

    modport slave (
        input  load_valid, load_data, load_len,
        output load_ready, x, x_valid, done, z_exp
    );
endinterface

`default_nettype wire

// File: rtl/serial_stream_tx.sv
// ============================================================================
// Module      : serial_stream_tx
// Description : MSB-first frame serializer with majority-of-3 reference output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_stream_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 3
) (
    input  wire logic          clk,
    input  wire logic          reset,
    serial_stream_tx_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_shreg;
    logic [LEN_W-1:0] r_cnt;
    logic [1:0]       r_hist;
    logic [1:0]       r_hcnt;

    logic             w_handshake;
    logic             w_shift;
    logic             w_x;
    logic             w_maj;

    assign w_handshake = bus.load_valid && (r_state == IDLE);
    assign w_shift     = (r_state == SHIFT);
    assign w_x         = w_shift ? r_shreg[WIDTH-1] : 1'b0;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.load_valid) w_next_state = SHIFT;
            SHIFT:   if (r_cnt == '0)    w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Shift register and bit counter are loaded only on handshake, so
    // load_valid seen while a frame is in flight cannot disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_handshake) begin
            r_shreg <= bus.load_data;
            r_cnt   <= bus.load_len;
        end else if (w_shift) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt - 1'b1;
        end
    end

    // Bit history spans frame boundaries; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= '0;
            r_hcnt <= '0;
        end else if (w_shift) begin
            r_hist <= {r_hist[0], w_x};
            if (r_hcnt != 2'd2) begin
                r_hcnt <= r_hcnt + 2'd1;
            end
        end
    end

    assign w_maj = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_x) | (r_hist[0] & w_x);

    assign bus.load_ready = (r_state == IDLE);
    assign bus.x          = w_x;
    assign bus.x_valid    = w_shift;
    assign bus.done       = (r_state == DONE);
    assign bus.z_exp      = w_shift && (r_hcnt == 2'd2) && w_maj;

endmodule

`default_nettype wire
